// File: rtl/multi_edge_detector_if.sv
// Bundle of per-channel inputs and detector outputs for multi_edge_detector.
// The detector is the slave; the driving logic is the master.
interface multi_edge_detector_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0]   data;
  logic [2*WIDTH-1:0] mode;
  logic [WIDTH-1:0]   clear;
  logic               clear_count;
  logic [WIDTH-1:0]   level;
  logic [WIDTH-1:0]   pulse;
  logic [WIDTH-1:0]   sticky;
  logic               any_event;
  logic [CNT_W-1:0]   event_count;

  modport master (
    output data, mode, clear, clear_count,
    input  level, pulse, sticky, any_event, event_count
  );

  modport slave (
    input  data, mode, clear, clear_count,
    output level, pulse, sticky, any_event, event_count
  );
endinterface

// File: rtl/multi_edge_detector.sv
// Multi-channel synchronise / debounce / edge-detect block.
// Each channel synchronises its raw input, accepts a level change only after
// DEBOUNCE stable cycles, and emits a mode-qualified one-cycle pulse on the
// accepting edge. Pulses set per-channel sticky flags and feed a saturating
// event counter shared by all channels.
module multi_edge_detector #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  multi_edge_detector_if.slave   bus
);

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE - 1);
  localparam logic [CNT_W+6:0] CNT_MAX = {7'd0, {CNT_W{1'b1}}};

  // Number of pulse bits set this cycle (WIDTH <= 32 fits in 6 bits).
  function automatic logic [5:0] popcount(input logic [WIDTH-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

  // Add without wrapping: clamp at the all-ones counter value.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [5:0]       b);
    logic [CNT_W+6:0] sum;
    sum = {7'd0, a} + {{(CNT_W+1){1'b0}}, b};
    if (sum > CNT_MAX) begin
      return {CNT_W{1'b1}};
    end
    return sum[CNT_W-1:0];
  endfunction

  // Stage 0 is the first synchroniser flop; the last stage is the clean level.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d, sync_q;
  logic [WIDTH-1:0][CW-1:0]          cnt_d, cnt_q;
  logic [WIDTH-1:0]                  level_d, level_q;
  logic [WIDTH-1:0]                  pulse_d, pulse_q;
  logic [WIDTH-1:0]                  sticky_d, sticky_q;
  logic [CNT_W-1:0]                  count_d, count_q;
  logic [WIDTH-1:0]                  s;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the synchroniser chain by one stage per clock.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.data};
  end

  // Debounce each channel and qualify accepted changes with its mode bits.
  // A mismatch that disappears before the counter reaches DB_MAX resets it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          level_d[i] = s[i];
          pulse_d[i] = s[i] ? bus.mode[2*i] : bus.mode[2*i+1];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Sticky flags: a new pulse beats a simultaneous clear.
  always_comb begin
    sticky_d = pulse_d | (sticky_q & ~bus.clear);
  end

  // Event counter: clear_count reloads with this cycle's pulses instead of 0.
  always_comb begin
    if (bus.clear_count) begin
      count_d = sat_add('0, popcount(pulse_d));
    end else begin
      count_d = sat_add(count_q, popcount(pulse_d));
    end
  end

  // All state, including the synchronisers, clears on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign bus.level       = level_q;
  assign bus.pulse       = pulse_q;
  assign bus.sticky      = sticky_q;
  assign bus.any_event   = |sticky_q;
  assign bus.event_count = count_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench for multi_edge_detector: stimulus queues expected pulses
// (channel, edge) and expected output snapshots; a negedge monitor pops them.
module tb_multi_edge_detector;

  localparam int K_LEVEL  = 0;
  localparam int K_PULSE  = 1;
  localparam int K_STICKY = 2;
  localparam int K_ANY    = 3;
  localparam int K_COUNT  = 4;
  localparam int K_BCOUNT = 5;

  typedef struct {
    int ch;
    int edge_no;
  } pexp_t;

  typedef struct {
    int          edge_no;
    int          kind;
    logic [31:0] mask;
    logic [31:0] val;
    string       name;
  } sexp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;
  bit   mon_done = 1'b0;

  pexp_t pq[$];
  sexp_t sq[$];

  multi_edge_detector_if #(.WIDTH(8), .CNT_W(16)) bus_a ();
  multi_edge_detector_if #(.WIDTH(8), .CNT_W(4))  bus_b ();

  multi_edge_detector #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(4), .CNT_W(16)) dut_a (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  multi_edge_detector #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(4), .CNT_W(4)) dut_b (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_LEVEL:  return {24'd0, bus_a.level};
      K_PULSE:  return {24'd0, bus_a.pulse};
      K_STICKY: return {24'd0, bus_a.sticky};
      K_ANY:    return {31'd0, bus_a.any_event};
      K_COUNT:  return {16'd0, bus_a.event_count};
      default:  return {28'd0, bus_b.event_count};
    endcase
  endfunction

  // Monitor: pulses against the pulse queue, snapshots against their edge.
  initial forever begin
    pexp_t       pe;
    sexp_t       se;
    logic [31:0] act;
    @(negedge clk);
    for (int ch = 0; ch < 8; ch++) begin
      if (bus_a.pulse[ch]) begin
        total++;
        if (pq.size() == 0) begin
          bad++;
          $display("FAIL pulse_unexpected ch=%0d edge=%0d got=1 want=0", ch, cyc);
        end else begin
          pe = pq.pop_front();
          if (pe.ch != ch || pe.edge_no != cyc) begin
            bad++;
            $display("FAIL pulse_match got ch=%0d edge=%0d want ch=%0d edge=%0d",
                     ch, cyc, pe.ch, pe.edge_no);
          end
        end
      end
    end
    while (pq.size() > 0 && pq[0].edge_no < cyc) begin
      pe = pq.pop_front();
      total++;
      bad++;
      $display("FAIL pulse_missing ch=%0d want edge=%0d got none by edge=%0d",
               pe.ch, pe.edge_no, cyc);
    end
    while (sq.size() > 0 && sq[0].edge_no <= cyc) begin
      se  = sq.pop_front();
      act = actual(se.kind) & se.mask;
      total++;
      if (act !== se.val) begin
        bad++;
        $display("FAIL %s edge=%0d got=%0h want=%0h", se.name, cyc, act, se.val);
      end
    end
    if (done && !mon_done) begin
      total++;
      if (pq.size() != 0) begin
        bad++;
        $display("FAIL pulses_left got=%0d want=0", pq.size());
      end
      mon_done = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic exp_pulse(input int ch, input int dly);
    pexp_t p;
    p.ch = ch;
    p.edge_no = cyc + dly;
    pq.push_back(p);
  endtask

  task automatic exp_now(input int kind, input logic [31:0] mask,
                         input logic [31:0] val, input string name);
    sexp_t s;
    s.edge_no = cyc;
    s.kind = kind;
    s.mask = mask;
    s.val = val;
    s.name = name;
    sq.push_back(s);
  endtask

  initial begin
    reset_n = 1'b0;
    bus_a.data = '0;
    bus_a.mode = 16'h5555;
    bus_a.clear = '0;
    bus_a.clear_count = 1'b0;
    bus_b.data = '0;
    bus_b.mode = 16'hFFFF;
    bus_b.clear = '0;
    bus_b.clear_count = 1'b0;

    // Reset state
    tick(3);
    exp_now(K_LEVEL,  32'hFF, 32'h0, "rst_level");
    exp_now(K_PULSE,  32'hFF, 32'h0, "rst_pulse");
    exp_now(K_STICKY, 32'hFF, 32'h0, "rst_sticky");
    exp_now(K_ANY,    32'h1,  32'h0, "rst_any");
    exp_now(K_COUNT,  32'hFFFF, 32'h0, "rst_count");
    reset_n = 1'b1;
    tick(1);

    // Rising detect on ch0, latency 6 edges
    bus_a.data[0] = 1'b1;
    exp_pulse(0, 6);
    tick(5);
    exp_now(K_LEVEL, 32'h01, 32'h00, "rise_level_early");
    tick(1);
    exp_now(K_LEVEL, 32'h01, 32'h01, "rise_level");
    tick(1);
    exp_now(K_PULSE,  32'h01, 32'h00, "rise_pulse_low");
    exp_now(K_STICKY, 32'h01, 32'h01, "rise_sticky");
    exp_now(K_ANY,    32'h1,  32'h1,  "rise_any");
    exp_now(K_COUNT,  32'hFFFF, 32'd1, "rise_count");

    // Glitch of 3 cycles on ch3 is rejected
    bus_a.data[3] = 1'b1;
    tick(3);
    bus_a.data[3] = 1'b0;
    tick(10);
    exp_now(K_LEVEL, 32'h08, 32'h00, "glitch_level");
    exp_now(K_COUNT, 32'hFFFF, 32'd1, "glitch_count");

    // Modes: ch0=01 ch1=10 ch2=11 ch3=00, others 01
    bus_a.mode = 16'h5539;
    bus_a.data[0] = 1'b0;
    tick(10);
    exp_now(K_LEVEL, 32'h0F, 32'h00, "mode_pre_level");
    bus_a.data[3:0] = 4'hF;
    exp_pulse(0, 6);
    exp_pulse(2, 6);
    tick(10);
    exp_now(K_LEVEL, 32'h0F, 32'h0F, "mode_level_hi");
    bus_a.data[3:0] = 4'h0;
    exp_pulse(1, 6);
    exp_pulse(2, 6);
    tick(10);
    exp_now(K_LEVEL,  32'h0F, 32'h00, "mode_level_lo");
    exp_now(K_COUNT,  32'hFFFF, 32'd5, "mode_count");
    exp_now(K_STICKY, 32'hFF, 32'h07, "mode_sticky");

    // Sticky clear and clear/set race on ch2
    bus_a.clear = 8'hFF;
    tick(1);
    bus_a.clear = 8'h00;
    exp_now(K_STICKY, 32'hFF, 32'h00, "clr_sticky");
    exp_now(K_ANY,    32'h1,  32'h0,  "clr_any");
    bus_a.data[2] = 1'b1;
    exp_pulse(2, 6);
    tick(5);
    bus_a.clear[2] = 1'b1;
    tick(1);
    exp_now(K_STICKY, 32'h04, 32'h04, "race_set_wins");
    tick(1);
    exp_now(K_STICKY, 32'h04, 32'h00, "race_clear");
    bus_a.clear[2] = 1'b0;
    exp_now(K_COUNT, 32'hFFFF, 32'd6, "race_count");

    // clear_count alone, then coinciding with two pulses
    bus_a.clear_count = 1'b1;
    tick(1);
    bus_a.clear_count = 1'b0;
    exp_now(K_COUNT, 32'hFFFF, 32'd0, "cc_zero");
    bus_a.data[0] = 1'b1;
    bus_a.data[2] = 1'b0;
    exp_pulse(0, 6);
    exp_pulse(2, 6);
    tick(5);
    bus_a.clear_count = 1'b1;
    tick(1);
    bus_a.clear_count = 1'b0;
    exp_now(K_COUNT, 32'hFFFF, 32'd2, "cc_load_pop");

    // Reset mid-debounce on ch5, input held high through release
    bus_a.data = 8'h00;
    tick(10);
    bus_a.data[5] = 1'b1;
    tick(3);
    reset_n = 1'b0;
    exp_now(K_LEVEL,  32'hFF, 32'h0, "rmid_level");
    exp_now(K_PULSE,  32'hFF, 32'h0, "rmid_pulse");
    exp_now(K_STICKY, 32'hFF, 32'h0, "rmid_sticky");
    exp_now(K_ANY,    32'h1,  32'h0, "rmid_any");
    exp_now(K_COUNT,  32'hFFFF, 32'h0, "rmid_count");
    tick(2);
    reset_n = 1'b1;
    exp_pulse(5, 6);
    tick(8);
    exp_now(K_LEVEL,  32'hFF, 32'h20, "rrel_level");
    exp_now(K_STICKY, 32'hFF, 32'h20, "rrel_sticky");
    exp_now(K_COUNT,  32'hFFFF, 32'd1, "rrel_count");

    // Saturation on the 4-bit counter instance
    exp_now(K_BCOUNT, 32'hF, 32'd0, "sat_start");
    bus_b.data = 8'hFF;
    tick(10);
    exp_now(K_BCOUNT, 32'hF, 32'd8, "sat_first8");
    bus_b.data = 8'h00;
    tick(10);
    exp_now(K_BCOUNT, 32'hF, 32'd15, "sat_reach");
    bus_b.data = 8'hFF;
    tick(10);
    bus_b.data = 8'h00;
    tick(10);
    exp_now(K_BCOUNT, 32'hF, 32'd15, "sat_hold");
    bus_b.clear_count = 1'b1;
    tick(1);
    bus_b.clear_count = 1'b0;
    exp_now(K_BCOUNT, 32'hF, 32'd0, "sat_clear");

    tick(3);
    done = 1'b1;
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clock and reset_n.
REQ-002 Parameter WIDTH, default 8: number of independent input channels (legal range 1..32).
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser flops per channel (legal range 2 or more).
REQ-004 Parameter DEBOUNCE, default 4: consecutive stable cycles required to accept a level change (legal range 1 or more).
REQ-005 Parameter CNT_W, default 16: width of the event counter.
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 data  input  WIDTH  asynchronous raw inputs, one bit per channel.
REQ-009 mode  input  2*WIDTH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-010 clear  input  WIDTH  per-channel sticky-flag clear, one bit per channel.
REQ-011 clear_count  input  1  synchronous clear of event_count.
REQ-012 level  output  WIDTH  registered debounced level per channel.
REQ-013 pulse  output  WIDTH  registered one-cycle detect pulse per channel.
REQ-014 sticky  output  WIDTH  registered latched event flag per channel.
REQ-015 any_event  output  1  OR of all sticky bits.
REQ-016 event_count  output  CNT_W  saturating total of pulses across all channels.

Function
REQ-017 Each channel SHALL pass data[i] through a chain of SYNC_STAGES flops; the last stage is s[i].
REQ-018 Per-channel debounce counter, width clog2(DEBOUNCE)+1:
- s==level: counter <= 0.
- s!=level and counter==DEBOUNCE-1: level <= s and counter <= 0.
- s!=level otherwise: counter increments.
REQ-019 A disturbance on s shorter than DEBOUNCE cycles SHALL leave level unchanged and SHALL return the counter to 0.
REQ-020 pulse[i] SHALL assert on the same edge at which level[i] changes, for exactly one cycle, when the mode qualifies:
- 01: 0->1 change.
- 10: 1->0 change.
- 11: either change.
- 00: never.
REQ-021 Latency: data[i] stable before edge k changes level[i] and pulse[i] at edge k+SYNC_STAGES-1+DEBOUNCE.
REQ-022 level SHALL track the input in every mode, including 00.
REQ-023 mode SHALL be sampled on the same edge as the level update; a mode change applies from that edge onward, with no retroactive pulses.
REQ-024 sticky[i] SHALL be set by pulse[i] and cleared by clear[i]; when a set and a clear occur on the same edge, the set SHALL win.
REQ-025 When clear[i] is held, sticky[i] SHALL be 0 except in cycles following a set.
REQ-026 any_event SHALL be the combinational OR of the sticky register bits.
REQ-027 event_count SHALL add the popcount of the pulse bits set in this cycle (0..WIDTH) each cycle and saturate at 2^CNT_W-1, never wrapping.
REQ-028 When clear_count coincides with pulses, event_count SHALL load the popcount of those pulses rather than 0.
REQ-029 Channels SHALL be fully independent, with no cross-channel interaction except event_count and any_event.

Reset
REQ-030 reset_n low SHALL immediately clear to 0:
- all synchroniser flops;
- all debounce counters;
- level, pulse and sticky;
- event_count.
REQ-031 Reset asserted mid-debounce SHALL abandon the pending change with no pulse.
REQ-032 An input held high through reset release SHALL be reported as a rising edge after the normal latency.
REQ-033 Reset release SHALL need no synchronisation inside this block; the integrator supplies a release-synchronised reset_n.

Verification (WIDTH=8, SYNC_STAGES=2, DEBOUNCE=4, CNT_W=16)
REQ-034 Rising detect: mode=all 01, data[0] set 0->1 before edge 1 -> level[0] and pulse[0] high after edge 6, pulse[0] low after edge 7, sticky[0]=1, any_event=1, event_count=1.
REQ-035 Glitch reject: data[3] high for 3 cycles then low -> level[3]=0, no pulse, event_count unchanged.
REQ-036 Modes: ch0=01, ch1=10, ch2=11, ch3=00, each toggled 0->1->0 with 10-cycle holds -> pulse counts ch0=1, ch1=1, ch2=2, ch3=0; level follows on all four; event_count=4.
REQ-037 Clear race: clear[2]=1 on the same edge as pulse[2] -> sticky[2]=1; clear[2]=1 next cycle with no pulse -> sticky[2]=0.
REQ-038 Saturation: CNT_W=4, all 8 channels in mode 11 toggled together twice -> event_count=15, held at 15; clear_count with no pulses -> 0.
REQ-039 Reset mid-op: reset_n low at edge 4 during a debounce -> all outputs 0 at once; data held high through release -> pulse after SYNC_STAGES+DEBOUNCE edges.
